state_sequencer: RTL
====================

# state_sequencer

Instruction sequencer that produces the 6-bit `state` code consumed by the control unit, which registers `control_out`/`mem_write` from it. It steps fetch1→fetch2→fetch3, waits for IR to settle, decodes the opcode, walks the execute states, then returns to fetch. It stops in a halt state on END or on an illegal opcode, and counts completed instructions.

## Interface
- `DEC_WAIT`, default 2: bubble cycles between leaving fetch3 and sampling `ir_opcode` (2 covers the control unit's registered output plus the IR load); legal range 1–4.
- `clock` input 1: the single clock; all logic updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin execution from IDLE; sampled only in IDLE.
- `ir_opcode` input 8: opcode field of IR.
- `state` output 6: state code to the control unit; registered.
- `busy` output 1: high in every state except IDLE and HALT.
- `halted` output 1: high in HALT.
- `illegal_op` output 1: sticky; set when an unknown opcode is decoded.
- `instr_count` output 16: completed instructions; saturating.

## Operation
- `state` port codes (fixed): idle 0, fetch1 1, fetch2 2, fetch3 3, clac 4, ldac1 5, ldac2 6, ldac3 7, stac1 8, stac2 9, stac3 10, mvacr 11, mvrac 12, add 13, mul 14.
- Internal states DECW (the wait bubbles), DEC and HALT all drive `state`=0, so downstream produces all-zero controls.
- Opcodes: 8'h00 NOP, 8'h01 CLAC, 8'h02 LDAC, 8'h03 STAC, 8'h04 MVACR, 8'h05 MVRAC, 8'h06 ADD, 8'h07 MUL (see Configuration), 8'hFF END; any other value is illegal.
- Transitions:
  - IDLE goes to fetch1 when `start`=1; otherwise it stays in IDLE.
  - fetch1→fetch2→fetch3→DECW. DECW lasts `DEC_WAIT`−1 cycles, then goes to DEC.
  - DEC samples `ir_opcode`:
    - NOP → fetch1.
    - CLAC → clac. LDAC → ldac1. STAC → stac1. MVACR → mvacr. MVRAC → mvrac. ADD → add. MUL → mul.
    - END → HALT.
    - Illegal → HALT, with `illegal_op` set.
  - Sequences: ldac1→ldac2→ldac3, and stac1→stac2→stac3.
  - clac, ldac3, stac3, mvacr, mvrac, add and mul each go to fetch1.
  - HALT is absorbing; only `reset` leaves it.
- `instr_count` increments by 1 on every DEC→fetch1 (NOP) and on every last-execute-state→fetch1 transition. It holds at 16'hFFFF. END and illegal opcodes are not counted.
- `start` is ignored outside IDLE. `ir_opcode` is ignored outside DEC.

## Timing
- Reset (edge where `reset`=1) forces the following values after that edge, regardless of current state, including mid-sequence:
  - state machine to IDLE;
  - `state`=0, `busy`=0, `halted`=0, `illegal_op`=0, `instr_count`=0.
- Every state occupies exactly one cycle, except DECW, which totals `DEC_WAIT`−1 cycles.
- `start` is sampled high at edge k in IDLE. Then `state`=1 after edge k, 2 after k+1 and 3 after k+2. With `DEC_WAIT`=2, DEC is present after k+4 and the first execute code after k+5.
- Instruction period equals 3 + `DEC_WAIT` + N cycles, where N = 1 (clac, mvacr, mvrac, add, mul), 3 (ldac, stac) or 0 (NOP).
- `halted` and `illegal_op` rise on the same edge that enters HALT. `busy` falls on that same edge.
- `instr_count` updates on the same edge that `state` becomes 1.
- If `reset` and `start` are both high, `reset` wins.

## Configuration
- `SEQ_MUL_EN` defined: opcode 8'h07 decodes to mul (`state`=14, one cycle, then fetch1).
- `SEQ_MUL_EN` undefined: 8'h07 is illegal (HALT, `illegal_op`=1), and code 14 is never driven.

## Test plan
- Reset then idle: assert `reset` 2 cycles with `start`=0 → `state`=0, `busy`=0, `halted`=0, `illegal_op`=0 and `instr_count`=0, held for 10 cycles.
- CLAC: start pulse at edge k, `ir_opcode`=8'h01 → `state` sequence 1,2,3,0,0,4,1 after edges k..k+6; `instr_count`=1 after k+6.
- LDAC then STAC back-to-back → codes 5,6,7 then 1,2,3,0,0 then 8,9,10 then 1; `instr_count`=2; `busy` stays 1 throughout.
- Illegal 8'h42 → after DEC, `halted`=1, `illegal_op`=1, `busy`=0 and `state`=0. Later `start` pulses and opcode changes leave it unchanged; `instr_count` is unchanged.
- MUL 8'h07: with `SEQ_MUL_EN` → `state`=14 for one cycle, then 1. Without it → HALT with `illegal_op`=1.
- Reset while `state`=9 (stac2) → `state`=0 and `instr_count`=0 after that edge. A following start plus NOP gives 1,2,3,0,0,1 and `instr_count`=1.

Source files
------------

// File: rtl/state_sequencer.sv
// state_sequencer: instruction sequencer driving the 6-bit control state code.
// Steps fetch1..fetch3, waits DEC_WAIT-1 bubble cycles for IR to settle,
// decodes ir_opcode, walks the execute states and returns to fetch1.
// END or an unknown opcode parks the machine in HALT until reset.
// Optional feature: define SEQ_MUL_EN to decode opcode 8'h07 as MUL.
//
// Parameters:
//   DEC_WAIT    bubble cycles between leaving fetch3 and sampling ir_opcode (1..4)
// Ports:
//   clock       single clock, rising edge
//   reset       synchronous, active-high
//   start       begin execution from IDLE (ignored elsewhere)
//   ir_opcode   opcode field of IR, sampled only in DEC
//   state       registered state code to the control unit
//   busy        high in every state except IDLE and HALT
//   halted      high in HALT
//   illegal_op  sticky flag, set when an unknown opcode is decoded
//   instr_count completed instructions, saturating at 16'hFFFF
module state_sequencer #(
   parameter int unsigned DEC_WAIT = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  ir_opcode,
   output logic [5:0]  state,
   output logic        busy,
   output logic        halted,
   output logic        illegal_op,
   output logic [15:0] instr_count
);

   localparam int unsigned CODE_W = 6;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned WAIT_W = 2;

   typedef enum logic [4:0] {
      S_IDLE, S_F1, S_F2, S_F3, S_DECW, S_DEC, S_HALT,
      S_CLAC, S_LD1, S_LD2, S_LD3, S_ST1, S_ST2, S_ST3,
      S_MVACR, S_MVRAC, S_ADD, S_MUL
   } seq_t;

   seq_t              cur, nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic [CODE_W-1:0] code_nxt;
   logic              busy_nxt, halted_nxt;
   logic              retire, bad_op;

   // State register plus outputs registered from the next-state decode
   always_ff @(posedge clock) begin
      if (reset) begin
         cur         <= S_IDLE;
         wait_cnt    <= '0;
         state       <= '0;
         busy        <= 1'b0;
         halted      <= 1'b0;
         illegal_op  <= 1'b0;
         instr_count <= '0;
      end else begin
         cur      <= nxt;
         wait_cnt <= wait_nxt;
         state    <= code_nxt;
         busy     <= busy_nxt;
         halted   <= halted_nxt;
         if (bad_op)
            illegal_op <= 1'b1;
         if (retire && (instr_count != {CNT_W{1'b1}}))
            instr_count <= instr_count + CNT_W'(1);
      end
   end

   // Next-state, bubble counter, retire/illegal strobes and output codes
   always_comb begin
      nxt      = cur;
      wait_nxt = wait_cnt;
      retire   = 1'b0;
      bad_op   = 1'b0;
      code_nxt = '0;

      case (cur)
         S_IDLE: if (start) nxt = S_F1;
         S_F1:   nxt = S_F2;
         S_F2:   nxt = S_F3;
         S_F3: begin
            wait_nxt = '0;
            // DEC_WAIT=1 means no bubble at all: go straight to decode
            if (DEC_WAIT > 1) nxt = S_DECW;
            else              nxt = S_DEC;
         end
         S_DECW: begin
            if (wait_cnt == WAIT_W'(DEC_WAIT - 2)) nxt = S_DEC;
            else                                   wait_nxt = wait_cnt + WAIT_W'(1);
         end
         S_DEC: begin
            case (ir_opcode)
               8'h00: begin nxt = S_F1; retire = 1'b1; end
               8'h01: nxt = S_CLAC;
               8'h02: nxt = S_LD1;
               8'h03: nxt = S_ST1;
               8'h04: nxt = S_MVACR;
               8'h05: nxt = S_MVRAC;
               8'h06: nxt = S_ADD;
`ifdef SEQ_MUL_EN
               8'h07: nxt = S_MUL;
`endif
               8'hFF: nxt = S_HALT;
               default: begin nxt = S_HALT; bad_op = 1'b1; end
            endcase
         end
         S_LD1: nxt = S_LD2;
         S_LD2: nxt = S_LD3;
         S_ST1: nxt = S_ST2;
         S_ST2: nxt = S_ST3;
         S_CLAC, S_LD3, S_ST3, S_MVACR, S_MVRAC, S_ADD, S_MUL: begin
            nxt    = S_F1;
            retire = 1'b1;
         end
         S_HALT: nxt = S_HALT;
         default: nxt = S_IDLE;
      endcase

      // DECW, DEC, IDLE and HALT all present code 0 downstream
      case (nxt)
         S_F1:    code_nxt = CODE_W'(1);
         S_F2:    code_nxt = CODE_W'(2);
         S_F3:    code_nxt = CODE_W'(3);
         S_CLAC:  code_nxt = CODE_W'(4);
         S_LD1:   code_nxt = CODE_W'(5);
         S_LD2:   code_nxt = CODE_W'(6);
         S_LD3:   code_nxt = CODE_W'(7);
         S_ST1:   code_nxt = CODE_W'(8);
         S_ST2:   code_nxt = CODE_W'(9);
         S_ST3:   code_nxt = CODE_W'(10);
         S_MVACR: code_nxt = CODE_W'(11);
         S_MVRAC: code_nxt = CODE_W'(12);
         S_ADD:   code_nxt = CODE_W'(13);
         S_MUL:   code_nxt = CODE_W'(14);
         default: code_nxt = '0;
      endcase

      busy_nxt   = (nxt != S_IDLE) && (nxt != S_HALT);
      halted_nxt = (nxt == S_HALT);
   end

endmodule
